pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 6-stage core (if_id..mem_wb).

---
 rtl/pipe_stage_reg.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: per-lane valid/ctrl/payload with stall-vector decode
// into advance/hold/bubble actions, flush priority and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int WIDTH      = 32,
    parameter int CTRL_W     = 4,
    parameter int LANES      = 2,
    parameter int STALL_W    = 6,
    parameter int STAGE      = 4,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        i_valid,
    input  logic [LANES*CTRL_W-1:0] i_ctrl,
    input  logic [LANES*WIDTH-1:0]  i_data,
    output logic [LANES-1:0]        o_valid,
    output logic [LANES*CTRL_W-1:0] o_ctrl,
    output logic [LANES*WIDTH-1:0]  o_data,
    output logic                    o_bubble,
    output logic [CNT_W-1:0]        o_bubble_cnt
);
    localparam int CW = LANES * CTRL_W;
    localparam int DW = LANES * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } action_t;

    logic             s_cur_s;
    logic             s_nxt_s;
    logic             stall_unused_s;
    action_t          action_s;

    logic [LANES-1:0] valid_r;
    logic [CW-1:0]    ctrl_r;
    logic [DW-1:0]    data_r;
    logic             bubble_r;
    logic [CNT_W-1:0] cnt_r;

    logic [LANES-1:0] valid_nxt_s;
    logic [CW-1:0]    ctrl_nxt_s;
    logic [DW-1:0]    data_nxt_s;
    logic             bubble_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign s_cur_s        = stall[STAGE];
    // Only our own and the downstream stall bits matter; the rest are folded away here.
    assign stall_unused_s = ^stall;

    // The last stage has no downstream consumer, so it can never be held, only bubbled.
    if (STAGE < STALL_W - 1) begin : g_nxt
        assign s_nxt_s = stall[STAGE+1];
    end else begin : g_last
        assign s_nxt_s = 1'b0;
    end

    // Action decode, flush first; s_cur = 0 always advances regardless of s_nxt.
    always_comb begin
        action_s = ACT_ADVANCE;
        if (flush) begin
            action_s = ACT_FLUSH;
        end else if (s_cur_s && !s_nxt_s) begin
            action_s = ACT_BUBBLE;
        end else if (s_cur_s) begin
            action_s = ACT_HOLD;
        end else begin
            action_s = ACT_ADVANCE;
        end
    end

    // Next register values for the decoded action.
    always_comb begin
        valid_nxt_s  = valid_r;
        ctrl_nxt_s   = ctrl_r;
        data_nxt_s   = data_r;
        bubble_nxt_s = 1'b0;
        cnt_nxt_s    = cnt_r;
        case (action_s)
            ACT_FLUSH: begin
                valid_nxt_s = {LANES{1'b0}};
                ctrl_nxt_s  = {CW{1'b0}};
                data_nxt_s  = {DW{1'b0}};
            end
            ACT_BUBBLE: begin
                valid_nxt_s  = {LANES{1'b0}};
                ctrl_nxt_s   = {CW{1'b0}};
                bubble_nxt_s = 1'b1;
                if (CLEAR_DATA != 0) begin
                    data_nxt_s = {DW{1'b0}};
                end else begin
                    data_nxt_s = data_r;
                end
                if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ACT_HOLD: begin
                valid_nxt_s = valid_r;
                ctrl_nxt_s  = ctrl_r;
                data_nxt_s  = data_r;
            end
            ACT_ADVANCE: begin
                valid_nxt_s = i_valid;
                ctrl_nxt_s  = i_ctrl;
                data_nxt_s  = i_data;
            end
            default: begin
                valid_nxt_s = {LANES{1'b0}};
                ctrl_nxt_s  = {CW{1'b0}};
                data_nxt_s  = {DW{1'b0}};
            end
        endcase
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r  <= {LANES{1'b0}};
            ctrl_r   <= {CW{1'b0}};
            data_r   <= {DW{1'b0}};
            bubble_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            valid_r  <= valid_nxt_s;
            ctrl_r   <= ctrl_nxt_s;
            data_r   <= data_nxt_s;
            bubble_r <= bubble_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign o_valid      = valid_r;
    assign o_ctrl       = ctrl_r;
    assign o_data       = data_r;
    assign o_bubble     = bubble_r;
    assign o_bubble_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: default (clear), hold-data and last-stage/4-bit-counter
// instances; table vectors go through an expected-value queue, corner cases are hand-written.
module tb_pipe_stage_reg;
    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic [5:0]  stall_c;
    logic        flush;
    logic [1:0]  i_valid;
    logic [7:0]  i_ctrl;
    logic [63:0] i_data;

    logic [1:0]  valid_a, valid_b, valid_c;
    logic [7:0]  ctrl_a, ctrl_b, ctrl_c;
    logic [63:0] data_a, data_b, data_c;
    logic        bub_a, bub_b, bub_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] D0   = 64'hDEAD_BEEF_1234_5678;
    localparam logic [63:0] D1   = 64'h0BAD_F00D_CAFE_BABE;
    localparam logic [63:0] D2   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3   = 64'hA5A5_A5A5_5A5A_5A5A;
    localparam logic [63:0] D4   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D5   = 64'hFEDC_BA98_7654_3210;

    pipe_stage_reg u_a (
        .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
        .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data),
        .o_valid(valid_a), .o_ctrl(ctrl_a), .o_data(data_a),
        .o_bubble(bub_a), .o_bubble_cnt(cnt_a)
    );

    pipe_stage_reg #(.CLEAR_DATA(0)) u_b (
        .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
        .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data),
        .o_valid(valid_b), .o_ctrl(ctrl_b), .o_data(data_b),
        .o_bubble(bub_b), .o_bubble_cnt(cnt_b)
    );

    pipe_stage_reg #(.STAGE(5), .CNT_W(4)) u_c (
        .clk(clk), .reset(rst_n), .stall(stall_c), .flush(flush),
        .i_valid(i_valid), .i_ctrl(i_ctrl), .i_data(i_data),
        .o_valid(valid_c), .o_ctrl(ctrl_c), .o_data(data_c),
        .o_bubble(bub_c), .o_bubble_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [1:0]  iv;
        logic [7:0]  ic;
        logic [63:0] id;
        logic [1:0]  ev;
        logic [7:0]  ec;
        logic [63:0] eda;
        logic [63:0] edb;
        logic        eb;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];
    int   cnt_q[$];

    function automatic vec_t mk(input logic [5:0] st, input logic fl, input logic [1:0] iv,
                                input logic [7:0] ic, input logic [63:0] id,
                                input logic [1:0] ev, input logic [7:0] ec,
                                input logic [63:0] eda, input logic [63:0] edb,
                                input logic eb, input logic [15:0] ecnt);
        vec_t v;
        v.stall = st; v.flush = fl; v.iv = iv; v.ic = ic; v.id = id;
        v.ev = ev; v.ec = ec; v.eda = eda; v.edb = edb; v.eb = eb; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid_a"}, 64'(valid_a), 64'd0);
        chk({nm, "_ctrl_a"},  64'(ctrl_a),  64'd0);
        chk({nm, "_data_a"},  data_a,       64'd0);
        chk({nm, "_bub_a"},   64'(bub_a),   64'd0);
        chk({nm, "_cnt_a"},   64'(cnt_a),   64'd0);
    endtask

    initial begin
        vec_t e;
        int   exp_c;
        rst_n = 1'b0; flush = 1'b0; stall = 6'd0; stall_c = 6'd0;
        i_valid = 2'b11; i_ctrl = 8'hFF; i_data = ONES;

        vecs[0]  = mk(6'b000000, 1'b0, 2'b11, 8'h5A, D0,   2'b11, 8'h5A, D0,    D0,    1'b0, 16'd0);
        vecs[1]  = mk(6'b110000, 1'b0, 2'b00, 8'hFF, ONES, 2'b11, 8'h5A, D0,    D0,    1'b0, 16'd0);
        vecs[2]  = mk(6'b110000, 1'b0, 2'b00, 8'hFF, ONES, 2'b11, 8'h5A, D0,    D0,    1'b0, 16'd0);
        vecs[3]  = mk(6'b110000, 1'b0, 2'b00, 8'hFF, ONES, 2'b11, 8'h5A, D0,    D0,    1'b0, 16'd0);
        vecs[4]  = mk(6'b010000, 1'b0, 2'b11, 8'hFF, ONES, 2'b00, 8'h00, 64'd0, D0,    1'b1, 16'd1);
        vecs[5]  = mk(6'b000000, 1'b0, 2'b01, 8'h3C, D1,   2'b01, 8'h3C, D1,    D1,    1'b0, 16'd1);
        vecs[6]  = mk(6'b010000, 1'b1, 2'b11, 8'hFF, ONES, 2'b00, 8'h00, 64'd0, 64'd0, 1'b0, 16'd1);
        vecs[7]  = mk(6'b000000, 1'b0, 2'b10, 8'hC3, D2,   2'b10, 8'hC3, D2,    D2,    1'b0, 16'd1);
        vecs[8]  = mk(6'b000000, 1'b1, 2'b11, 8'hFF, ONES, 2'b00, 8'h00, 64'd0, 64'd0, 1'b0, 16'd1);
        vecs[9]  = mk(6'b000000, 1'b0, 2'b00, 8'h96, D3,   2'b00, 8'h96, D3,    D3,    1'b0, 16'd1);
        vecs[10] = mk(6'b100000, 1'b0, 2'b11, 8'h21, D4,   2'b11, 8'h21, D4,    D4,    1'b0, 16'd1);
        vecs[11] = mk(6'b010000, 1'b0, 2'b11, 8'hFF, ONES, 2'b00, 8'h00, 64'd0, D4,    1'b1, 16'd2);
        vecs[12] = mk(6'b010000, 1'b0, 2'b11, 8'hFF, ONES, 2'b00, 8'h00, 64'd0, D4,    1'b1, 16'd3);
        vecs[13] = mk(6'b110000, 1'b0, 2'b11, 8'hFF, ONES, 2'b00, 8'h00, 64'd0, D4,    1'b0, 16'd3);
        vecs[14] = mk(6'b001111, 1'b0, 2'b11, 8'hE7, D5,   2'b11, 8'hE7, D5,    D5,    1'b0, 16'd3);
        vecs[15] = mk(6'b010000, 1'b0, 2'b01, 8'h11, D0,   2'b00, 8'h00, 64'd0, D5,    1'b1, 16'd4);

        // Reset: held low, then released with all-ones inputs, then an asynchronous mid-cycle pulse.
        #1;
        chk_zero("rst_hold");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_data_a", data_a, ONES);
        chk("pre_rst_ctrl_a", 64'(ctrl_a), 64'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        chk("rst_async_data_b", data_b, 64'd0);
        chk("rst_async_data_c", data_c, 64'd0);
        chk("rst_async_cnt_c",  64'(cnt_c), 64'd0);
        @(posedge clk); #1;
        chk_zero("rst_low_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("rst_released");
        @(posedge clk); #1;
        chk("rst_first_adv_data_a",  data_a, ONES);
        chk("rst_first_adv_valid_a", 64'(valid_a), 64'h3);

        // Table vectors: expected record queued at drive time, popped after the edge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            stall = vecs[i].stall; flush = vecs[i].flush;
            i_valid = vecs[i].iv; i_ctrl = vecs[i].ic; i_data = vecs[i].id;
            sb_q.push_back(vecs[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            chk($sformatf("v%0d_valid_a", i), 64'(valid_a), 64'(e.ev));
            chk($sformatf("v%0d_ctrl_a", i),  64'(ctrl_a),  64'(e.ec));
            chk($sformatf("v%0d_data_a", i),  data_a,       e.eda);
            chk($sformatf("v%0d_bub_a", i),   64'(bub_a),   64'(e.eb));
            chk($sformatf("v%0d_cnt_a", i),   64'(cnt_a),   64'(e.ecnt));
            chk($sformatf("v%0d_valid_b", i), 64'(valid_b), 64'(e.ev));
            chk($sformatf("v%0d_ctrl_b", i),  64'(ctrl_b),  64'(e.ec));
            chk($sformatf("v%0d_data_b", i),  data_b,       e.edb);
            chk($sformatf("v%0d_bub_b", i),   64'(bub_b),   64'(e.eb));
            chk($sformatf("v%0d_cnt_b", i),   64'(cnt_b),   64'(e.ecnt));
        end

        // Last stage, 4-bit counter: repeated bubbles saturate at 15; all-ones stall is still a bubble.
        exp_c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stall = 6'b110000; flush = 1'b0;
            stall_c = (i % 2 == 1) ? 6'b111111 : 6'b100000;
            i_valid = 2'b11; i_ctrl = 8'hFF; i_data = ONES;
            exp_c = (exp_c == 15) ? 15 : exp_c + 1;
            cnt_q.push_back(exp_c);
            @(posedge clk); #1;
            chk($sformatf("sat%0d_cnt_c", i),   64'(cnt_c), 64'(cnt_q.pop_front()));
            chk($sformatf("sat%0d_bub_c", i),   64'(bub_c), 64'd1);
            chk($sformatf("sat%0d_valid_c", i), 64'(valid_c) | 64'(ctrl_c), 64'd0);
            chk($sformatf("sat%0d_data_c", i),  data_c, 64'd0);
        end
        chk("hold_during_sat_data_b", data_b, D5);
        chk("hold_during_sat_cnt_a",  64'(cnt_a), 64'd4);

        // Flush beats bubble on the last stage; saturated count is untouched.
        @(negedge clk);
        flush = 1'b1; stall_c = 6'b100000;
        @(posedge clk); #1;
        chk("flush_c_bub",   64'(bub_c), 64'd0);
        chk("flush_c_cnt",   64'(cnt_c), 64'd15);
        chk("flush_c_valid", 64'(valid_c), 64'd0);
        chk("flush_a_cnt",   64'(cnt_a), 64'd4);
        chk("flush_b_data",  data_b, 64'd0);
        @(negedge clk);
        flush = 1'b0; stall_c = 6'b000000; stall = 6'b000000;
        i_valid = 2'b10; i_ctrl = 8'h7E; i_data = D2;
        @(posedge clk); #1;
        chk("post_flush_adv_data_c", data_c, D2);
        chk("post_flush_adv_ctrl_c", 64'(ctrl_c), 64'h7E);
        chk("post_flush_adv_cnt_c",  64'(cnt_c), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
